multi_cycle_cpu_core: RTL and testbench
=======================================

// Module: multi_cycle_cpu_core
// PURPOSE
//  Non-pipelined MIPS-subset CPU. Each instruction walks a 5-state FSM (IF/ID/EXE/MEM/WB), one state per clock.
//  Holds its own instruction ROM, data RAM and 32x32 register file; sits at top level of the lab board.
//  Debug ports expose register file, data memory, per-stage PC and FSM state for the board display.
// PARAMETERS
//  IMEM_DEPTH  32          instruction ROM words, word-addressed by pc[6:2]
//  DMEM_DEPTH  32          data RAM words, word-addressed by addr[6:2]
//  IMEM_FILE   "inst.mem"  hex file loaded into ROM via $readmemh at time 0
// PORTS
//  clk           in   1   single system clock, rising edge
//  resetn        in   1   asynchronous active-low reset
//  rf_addr       in   5   debug register-file read index
//  mem_addr      in   32  debug data-RAM byte address, word index = mem_addr[6:2]
//  rf_data       out  32  regfile[rf_addr], combinational; 0 when rf_addr==0
//  mem_data      out  32  dmem[mem_addr[6:2]], combinational
//  IF_pc         out  32  PC of current instr when state==IF, else 0
//  IF_inst       out  32  imem[pc[6:2]] (current instruction word), always driven
//  ID_pc         out  32  PC of current instr when state==ID, else 0
//  EXE_pc        out  32  PC of current instr when state==EXE, else 0
//  MEM_pc        out  32  PC of current instr when state==MEM, else 0
//  WB_pc         out  32  PC of current instr when state==WB, else 0
//  display_state out  32  {29'b0, state}: IF=1 ID=2 EXE=3 MEM=4 WB=5
// BEHAVIOUR
//  - Reset (resetn=0, async): pc=0, state=IF, instr/ALU/load regs=0; regfile all 0; dmem cleared to 0.
//    Outputs in reset: IF_pc=0, other *_pc=0, display_state=1. Reset mid-instruction aborts it, no writes.
//  - Instr set: ADDU SUBU AND OR XOR NOR SLT SLL SRL (R-type), ADDIU SLTI ANDI ORI XORI LUI, LW SW, BEQ BNE, J.
//    ANDI/ORI/XORI zero-extend imm; ADDIU/SLTI/LW/SW/BEQ/BNE sign-extend; LUI = {imm,16'b0}.
//    All arithmetic 32-bit wraparound, no overflow trap; SLT/SLTI signed compare.
//  - IF (1 clk): instr register <= imem[pc[6:2]]. -> ID.
//  - ID: read rs/rt into operand regs, decode. J: pc <= {pc+4[31:28], target, 2'b00}, -> IF.
//    Undefined opcode/funct: executed as NOP, pc <= pc+4, -> IF.
//  - EXE: ALU result registered. BEQ/BNE: pc <= taken ? pc+4+(sext(imm)<<2) : pc+4, -> IF.
//    LW/SW -> MEM; all other ALU ops -> WB.
//  - MEM: SW writes dmem[addr[6:2]] <= rt at clock edge, pc <= pc+4, -> IF. LW latches dmem word, -> WB.
//  - WB: regfile[rd or rt] <= result (writes to r0 discarded), pc <= pc+4, -> IF.
//  - CPI: J/NOP 2, branch 3, SW 4, ALU 4, LW 5. pc increments/updates only at end of instruction's last state.
//  - Addresses beyond memory depth wrap (index uses low bits only); misaligned low 2 bits ignored.
//  - Debug reads are read-only; a debug read of a register written this cycle shows the old value until the edge.
// TESTING
//  1 Reset held 100ns, clk period 10ns -> display_state=1, IF_pc=0, all rf_data=0; release -> state 1,2,3,5,1 for ALU op.
//  2 ADDIU r1,r0,5 at pc 0 -> after 4 clks rf_data(1)=5, IF_pc=4; ADDU r2,r1,r1 -> r2=10; SUBU r3,r0,r1 -> 0xFFFFFFFB.
//  3 SW r2,8(r0) then LW r4,8(r0) -> mem_data(mem_addr=8)=10 after SW's MEM, r4=10 after 5-clk LW; MEM_pc shown in MEM.
//  4 BEQ r1,r1,+2 at pc 0x10 -> next IF_pc=0x1C after 3 clks; BNE same operands -> IF_pc=0x14.
//  5 J 0x0 at pc 0x20 -> ID->IF, IF_pc=0 after 2 clks; ADDIU r0,r0,7 -> rf_data(0) stays 0.
//  6 Assert resetn low during EXE of an ALU instr -> no regfile write, pc=0, state IF immediately (async).

Source files
------------

// File: rtl/multi_cycle_cpu_core_if.sv
// multi_cycle_cpu_core_if: debug bus between the core and the lab-board display
interface multi_cycle_cpu_core_if;
    logic [4:0]  rf_addr;
    logic [31:0] mem_addr, rf_data, mem_data, IF_pc, IF_inst, ID_pc, EXE_pc, MEM_pc, WB_pc, display_state;
    modport master (input rf_addr, mem_addr,
                    output rf_data, mem_data, IF_pc, IF_inst, ID_pc, EXE_pc, MEM_pc, WB_pc, display_state);
    modport slave (output rf_addr, mem_addr,
                   input rf_data, mem_data, IF_pc, IF_inst, ID_pc, EXE_pc, MEM_pc, WB_pc, display_state);
endinterface

// File: rtl/multi_cycle_cpu_core.sv
// multi_cycle_cpu_core: non-pipelined MIPS-subset CPU, one FSM state (IF/ID/EXE/MEM/WB) per clock.
// ROM image comes from IMEM_INIT (word i at bits [32*i +: 32]) so the core needs no file-based init.
module multi_cycle_cpu_core #(
    parameter int IMEM_DEPTH = 32,
    parameter int DMEM_DEPTH = 32,
    parameter logic [IMEM_DEPTH*32-1:0] IMEM_INIT = '0
) (
    input logic clk,
    input logic resetn,
    multi_cycle_cpu_core_if.master dbg
);
    localparam int IW = $clog2(IMEM_DEPTH);
    localparam int DW = $clog2(DMEM_DEPTH);
    typedef enum logic [2:0] {S_IF = 3'd1, S_ID = 3'd2, S_EXE = 3'd3, S_MEM = 3'd4, S_WB = 3'd5} state_t;
    state_t state, state_nx;
    logic [31:0] pc, ir, a, b, alu_r, mdr, pc_nx, alu_nx, inst, sx, zx, y, pc4, br_t, j_t, slt;
    logic [31:0] rf [32];
    logic [31:0] dmem [DMEM_DEPTH];
    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd, sh, dst;
    logic [DW-1:0] didx;
    logic is_r, is_lw, is_sw, is_br, is_j, is_alu, valid, pc_we, rf_we, dm_we, unused_ok;
    assign inst = IMEM_INIT[{pc[IW+1:2], 5'b0} +: 32];
    assign {op, rs, rt, rd, sh, fn} = ir;
    assign sx = {{16{ir[15]}}, ir[15:0]};
    assign zx = {16'b0, ir[15:0]};
    assign pc4 = pc + 32'd4;
    assign br_t = pc4 + {sx[29:0], 2'b00};
    assign j_t = {pc4[31:28], ir[25:0], 2'b00};
    assign didx = alu_r[DW+1:2];
    assign is_r = op == 6'h00 && (fn inside {6'h00, 6'h02, 6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a});
    assign is_lw = op == 6'h23;
    assign is_sw = op == 6'h2b;
    assign is_br = op == 6'h04 || op == 6'h05;
    assign is_j = op == 6'h02;
    assign is_alu = is_r || (op inside {6'h09, 6'h0a, 6'h0c, 6'h0d, 6'h0e, 6'h0f});
    assign valid = is_alu || is_lw || is_sw || is_br || is_j;
    assign dst = op == 6'h00 ? rd : rt;
    // logical immediates zero-extend, everything else sign-extends
    assign y = op == 6'h00 ? b : (op inside {6'h0c, 6'h0d, 6'h0e}) ? zx : sx;
    assign slt = {31'b0, $signed(a) < $signed(y)};
    assign alu_nx = op == 6'h00 ?
        (fn == 6'h00 ? b << sh : fn == 6'h02 ? b >> sh : fn == 6'h23 ? a - b : fn == 6'h24 ? a & b :
         fn == 6'h25 ? a | b : fn == 6'h26 ? a ^ b : fn == 6'h27 ? ~(a | b) : fn == 6'h2a ? slt : a + b) :
        op == 6'h0a ? slt : op == 6'h0c ? a & y : op == 6'h0d ? a | y : op == 6'h0e ? a ^ y :
        op == 6'h0f ? {ir[15:0], 16'b0} : a + y;
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) state <= S_IF;
        else state <= state_nx;
    always_comb begin
        state_nx = S_IF;
        case (state)
            S_IF:    state_nx = S_ID;
            S_ID:    state_nx = (is_j || !valid) ? S_IF : S_EXE;
            S_EXE:   state_nx = is_br ? S_IF : (is_lw || is_sw) ? S_MEM : S_WB;
            S_MEM:   state_nx = is_sw ? S_IF : S_WB;
            default: state_nx = S_IF;
        endcase
    end
    // pc only moves in the last state of each instruction
    always_comb begin
        pc_we = 1'b0;
        pc_nx = pc4;
        rf_we = 1'b0;
        dm_we = 1'b0;
        case (state)
            S_ID: begin
                pc_we = is_j || !valid;
                pc_nx = is_j ? j_t : pc4;
            end
            S_EXE: begin
                pc_we = is_br;
                pc_nx = ((a == b) ^ (op == 6'h05)) ? br_t : pc4;
            end
            S_MEM: begin
                pc_we = is_sw;
                dm_we = is_sw;
            end
            S_WB: begin
                pc_we = 1'b1;
                rf_we = dst != 5'd0;
            end
            default: pc_we = 1'b0;
        endcase
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc <= '0;
            ir <= '0;
            a <= '0;
            b <= '0;
            alu_r <= '0;
            mdr <= '0;
            for (int i = 0; i < 32; i++) rf[i] <= '0;
            for (int i = 0; i < DMEM_DEPTH; i++) dmem[i] <= '0;
        end else begin
            if (state == S_IF) ir <= inst;
            if (state == S_ID) begin
                a <= rf[rs];
                b <= rf[rt];
            end
            if (state == S_EXE) alu_r <= alu_nx;
            if (state == S_MEM) mdr <= dmem[didx];
            if (pc_we) pc <= pc_nx;
            if (rf_we) rf[dst] <= is_lw ? mdr : alu_r;
            if (dm_we) dmem[didx] <= b;
        end
    end
    assign dbg.rf_data = dbg.rf_addr == 5'd0 ? 32'd0 : rf[dbg.rf_addr];
    assign dbg.mem_data = dmem[dbg.mem_addr[DW+1:2]];
    assign dbg.IF_inst = inst;
    assign dbg.IF_pc = state == S_IF ? pc : 32'd0;
    assign dbg.ID_pc = state == S_ID ? pc : 32'd0;
    assign dbg.EXE_pc = state == S_EXE ? pc : 32'd0;
    assign dbg.MEM_pc = state == S_MEM ? pc : 32'd0;
    assign dbg.WB_pc = state == S_WB ? pc : 32'd0;
    assign dbg.display_state = {29'b0, state};
    assign unused_ok = ^{dbg.mem_addr[31:DW+2], dbg.mem_addr[1:0]};
endmodule

// File: tb/tb_multi_cycle_cpu_core.sv
// tb_multi_cycle_cpu_core: directed program run through the core with hand-computed expectations.
module tb_multi_cycle_cpu_core;
    localparam logic [32*32-1:0] PROG = {352'b0,
        32'h08000000, 32'h000777C2, 32'h306DFF00, 32'h386CFFFF, 32'h286BFFFF, 32'h00005027, 32'h00014900,
        32'h00E1402A, 32'h3C078000, 32'h3426F0F0, 32'hFC000000, 32'h24000007, 32'h14210002, 32'h24050001,
        32'h24050001, 32'h10210002, 32'h8C040088, 32'hAC020008, 32'h00011823, 32'h00211021, 32'h24010005};
    localparam logic [31:0] EXP [9] = '{32'h0000F0F5, 32'h80000000, 32'h1, 32'h50, 32'hFFFFFFFF,
                                         32'h1, 32'hFFFF0004, 32'h0000FF00, 32'h1};
    logic clk = 0, resetn = 0;
    int vectors = 0, miscompares = 0;
    multi_cycle_cpu_core_if dbg();
    multi_cycle_cpu_core #(.IMEM_INIT(PROG)) dut (.clk(clk), .resetn(resetn), .dbg(dbg));
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input int r, output logic [31:0] v);
        dbg.rf_addr = r[4:0];
        #1;
        v = dbg.rf_data;
    endtask

    task automatic test_reset;
        logic [31:0] v;
        resetn = 0;
        #100;
        vectors++; if (dbg.display_state !== 32'd1) begin miscompares++; $display("FAIL reset_state: got %0d want 1", dbg.display_state); end
        vectors++; if (dbg.IF_pc !== 32'd0) begin miscompares++; $display("FAIL reset_if_pc: got %h want 0", dbg.IF_pc); end
        vectors++; if ((dbg.ID_pc | dbg.EXE_pc | dbg.MEM_pc | dbg.WB_pc) !== 32'd0) begin miscompares++; $display("FAIL reset_stage_pcs: got nonzero want 0"); end
        for (int r = 0; r < 32; r++) begin
            rd(r, v);
            vectors++; if (v !== 32'd0) begin miscompares++; $display("FAIL reset_rf[%0d]: got %h want 0", r, v); end
        end
        @(negedge clk);
        resetn = 1;
        #1;
        vectors++; if (dbg.display_state !== 32'd1) begin miscompares++; $display("FAIL release_state: got %0d want 1", dbg.display_state); end
        vectors++; if (dbg.IF_inst !== 32'h24010005) begin miscompares++; $display("FAIL if_inst0: got %h want 24010005", dbg.IF_inst); end
    endtask

    task automatic test_alu;
        logic [31:0] v;
        tick(1);
        vectors++; if (dbg.display_state !== 32'd2 || dbg.ID_pc !== 32'd0) begin miscompares++; $display("FAIL addiu_id: got state %0d pc %h want 2/0", dbg.display_state, dbg.ID_pc); end
        tick(1);
        vectors++; if (dbg.display_state !== 32'd3 || dbg.EXE_pc !== 32'd0) begin miscompares++; $display("FAIL addiu_exe: got state %0d pc %h want 3/0", dbg.display_state, dbg.EXE_pc); end
        tick(1);
        vectors++; if (dbg.display_state !== 32'd5 || dbg.IF_pc !== 32'd0) begin miscompares++; $display("FAIL addiu_wb: got state %0d if_pc %h want 5/0", dbg.display_state, dbg.IF_pc); end
        rd(1, v);
        vectors++; if (v !== 32'd0) begin miscompares++; $display("FAIL addiu_pre_wb_r1: got %h want 0", v); end
        tick(1);
        rd(1, v);
        vectors++; if (dbg.display_state !== 32'd1 || dbg.IF_pc !== 32'd4) begin miscompares++; $display("FAIL addiu_next: got state %0d if_pc %h want 1/4", dbg.display_state, dbg.IF_pc); end
        vectors++; if (v !== 32'd5) begin miscompares++; $display("FAIL addiu_r1: got %h want 5", v); end
        tick(4);
        rd(2, v);
        vectors++; if (v !== 32'd10 || dbg.IF_pc !== 32'h8) begin miscompares++; $display("FAIL addu_r2: got %h pc %h want a/8", v, dbg.IF_pc); end
        tick(4);
        rd(3, v);
        vectors++; if (v !== 32'hFFFFFFFB || dbg.IF_pc !== 32'hC) begin miscompares++; $display("FAIL subu_r3: got %h pc %h want fffffffb/c", v, dbg.IF_pc); end
    endtask

    task automatic test_mem;
        logic [31:0] v;
        dbg.mem_addr = 32'h8;
        tick(3);
        vectors++; if (dbg.display_state !== 32'd4 || dbg.MEM_pc !== 32'hC) begin miscompares++; $display("FAIL sw_mem: got state %0d pc %h want 4/c", dbg.display_state, dbg.MEM_pc); end
        vectors++; if (dbg.mem_data !== 32'd0) begin miscompares++; $display("FAIL sw_pre_write: got %h want 0", dbg.mem_data); end
        tick(1);
        vectors++; if (dbg.mem_data !== 32'd10 || dbg.IF_pc !== 32'h10) begin miscompares++; $display("FAIL sw_write: got %h pc %h want a/10", dbg.mem_data, dbg.IF_pc); end
        tick(4);
        rd(4, v);
        vectors++; if (dbg.display_state !== 32'd5 || v !== 32'd0) begin miscompares++; $display("FAIL lw_wb: got state %0d r4 %h want 5/0", dbg.display_state, v); end
        tick(1);
        rd(4, v);
        vectors++; if (v !== 32'd10 || dbg.IF_pc !== 32'h14) begin miscompares++; $display("FAIL lw_r4: got %h pc %h want a/14", v, dbg.IF_pc); end
        dbg.mem_addr = 32'h8B;
        #1;
        vectors++; if (dbg.mem_data !== 32'd10) begin miscompares++; $display("FAIL mem_wrap: got %h want a", dbg.mem_data); end
    endtask

    task automatic test_branch;
        logic [31:0] v;
        tick(2);
        vectors++; if (dbg.display_state !== 32'd3) begin miscompares++; $display("FAIL beq_exe: got %0d want 3", dbg.display_state); end
        tick(1);
        vectors++; if (dbg.display_state !== 32'd1 || dbg.IF_pc !== 32'h20) begin miscompares++; $display("FAIL beq_taken: got state %0d pc %h want 1/20", dbg.display_state, dbg.IF_pc); end
        tick(3);
        vectors++; if (dbg.IF_pc !== 32'h24) begin miscompares++; $display("FAIL bne_not_taken: got %h want 24", dbg.IF_pc); end
        rd(5, v);
        vectors++; if (v !== 32'd0) begin miscompares++; $display("FAIL branch_skip_r5: got %h want 0", v); end
    endtask

    task automatic test_r0_nop;
        logic [31:0] v;
        tick(4);
        rd(0, v);
        vectors++; if (v !== 32'd0 || dbg.IF_pc !== 32'h28) begin miscompares++; $display("FAIL r0_write: got %h pc %h want 0/28", v, dbg.IF_pc); end
        tick(1);
        vectors++; if (dbg.display_state !== 32'd2) begin miscompares++; $display("FAIL nop_id: got %0d want 2", dbg.display_state); end
        tick(1);
        vectors++; if (dbg.display_state !== 32'd1 || dbg.IF_pc !== 32'h2C) begin miscompares++; $display("FAIL nop_next: got state %0d pc %h want 1/2c", dbg.display_state, dbg.IF_pc); end
    endtask

    task automatic test_alu_more;
        logic [31:0] v;
        for (int i = 0; i < 9; i++) begin
            tick(4);
            rd(6 + i, v);
            vectors++; if (v !== EXP[i] || dbg.IF_pc !== 32'h30 + 32'(4 * i)) begin miscompares++; $display("FAIL alu_r%0d: got %h pc %h want %h/%h", 6 + i, v, dbg.IF_pc, EXP[i], 32'h30 + 32'(4 * i)); end
        end
    endtask

    task automatic test_jump;
        tick(1);
        vectors++; if (dbg.display_state !== 32'd2 || dbg.ID_pc !== 32'h50) begin miscompares++; $display("FAIL j_id: got state %0d pc %h want 2/50", dbg.display_state, dbg.ID_pc); end
        tick(1);
        vectors++; if (dbg.display_state !== 32'd1 || dbg.IF_pc !== 32'd0) begin miscompares++; $display("FAIL j_target: got state %0d pc %h want 1/0", dbg.display_state, dbg.IF_pc); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] v;
        tick(4);
        tick(2);
        vectors++; if (dbg.display_state !== 32'd3 || dbg.EXE_pc !== 32'd4) begin miscompares++; $display("FAIL mid_exe: got state %0d pc %h want 3/4", dbg.display_state, dbg.EXE_pc); end
        resetn = 0;
        #1;
        vectors++; if (dbg.display_state !== 32'd1 || dbg.IF_pc !== 32'd0) begin miscompares++; $display("FAIL async_reset: got state %0d pc %h want 1/0", dbg.display_state, dbg.IF_pc); end
        rd(2, v);
        vectors++; if (v !== 32'd0) begin miscompares++; $display("FAIL async_reset_r2: got %h want 0", v); end
        dbg.mem_addr = 32'h8;
        #1;
        vectors++; if (dbg.mem_data !== 32'd0) begin miscompares++; $display("FAIL async_reset_dmem: got %h want 0", dbg.mem_data); end
        @(negedge clk);
        resetn = 1;
        tick(4);
        rd(1, v);
        vectors++; if (v !== 32'd5 || dbg.IF_pc !== 32'd4) begin miscompares++; $display("FAIL rerun_addiu: got %h pc %h want 5/4", v, dbg.IF_pc); end
    endtask

    initial begin
        dbg.rf_addr = '0;
        dbg.mem_addr = '0;
        test_reset;
        test_alu;
        test_mem;
        test_branch;
        test_r0_nop;
        test_alu_more;
        test_jump;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
